ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures the EX-stage results: GPR write (address, enable, data) and HI/LO write (hi, lo, enable), as produced by the move/arith/logic units and muxed in ex.
- Owns stall/flush sequencing for the EX/MEM boundary.
- Holds the multi-cycle MADD/MSUB accumulator state (partial product plus cycle count) across EX stalls and hands it back to EX.

Parameters:
- REG_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- STALL_W, 6, width of the pipeline stall vector (index 0 = PC ... 5 = WB)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high (`RstEnable)
- stall  in  STALL_W  pipeline stall vector from ctrl; bit 3 = EX stalled, bit 4 = MEM stalled
- flush  in  1  exception flush; kills the EX/MEM contents
- ex_wd  in  ADDR_W  destination GPR from EX
- ex_wreg  in  1  GPR write enable from EX
- ex_wdata  in  REG_W  GPR write data from EX
- ex_hi  in  REG_W  HI write value from EX
- ex_lo  in  REG_W  LO write value from EX
- ex_whilo  in  1  HI/LO write enable from EX
- hilo_i  in  2*REG_W  MADD/MSUB partial result from EX
- cnt_i  in  2  MADD/MSUB cycle count from EX
- mem_wd  out  ADDR_W  registered destination GPR
- mem_wreg  out  1  registered GPR write enable
- mem_wdata  out  REG_W  registered GPR write data
- mem_hi  out  REG_W  registered HI value
- mem_lo  out  REG_W  registered LO value
- mem_whilo  out  1  registered HI/LO write enable
- mem_valid  out  1  1 = slot holds a real instruction, 0 = bubble/empty
- hilo_o  out  2*REG_W  accumulator state returned to EX
- cnt_o  out  2  cycle count returned to EX

Behaviour:
- Reset (async, rst=1): every output is 0 (`ZeroWord / `WriteDisable / `NOPRegAddr). mem_valid=0. Applies immediately, no clock required. Reset mid-MADD discards the accumulator (hilo_o=0, cnt_o=0).
- One-cycle latency: EX values presented in cycle N appear on mem_* after the rising edge ending cycle N.
- Per-edge priority (highest first):
  1. flush=1: all mem_* cleared to reset values, mem_valid=0, hilo_o=0, cnt_o=0. Flush overrides any stall.
  2. stall[3]=1 and stall[4]=0 (EX stalled, MEM runs): insert a bubble. mem_wreg=0, mem_whilo=0, mem_wd=0, data fields=0, mem_valid=0. hilo_o<=hilo_i, cnt_o<=cnt_i (accumulator preserved for the next EX cycle).
  3. stall[3]=0 (EX advances): capture all ex_* into mem_*. mem_valid=1. hilo_o=0, cnt_o=0 (accumulation finished).
  4. stall[3]=1 and stall[4]=1: hold every register, including hilo_o and cnt_o.
- stall[4]=1 with stall[3]=0 is an illegal ctrl encoding. It is treated as a hold (case 4) so data is never lost.
- mem_valid is 2-state: EMPTY(0) to FULL(1) on capture; FULL to EMPTY on bubble or flush; unchanged on hold.
- mem_hi/mem_lo are carried unchanged even when mem_whilo=0. Downstream stages qualify them with mem_whilo.
- cnt_i is taken as-is, 0..3, with no saturation or wrap logic here.
- No combinational path from any input to any output.

Optional Feature:
- Macro: HILO_ACC_EN.
- Defined: the hilo_i/cnt_i to hilo_o/cnt_o accumulator path is present as described above.
- Undefined: the hilo_i and cnt_i ports are removed; hilo_o and cnt_o are tied to 0. MADD/MSUB are then unsupported, and EX must not request stalls for them.
- All other behaviour is identical in both builds.

Test Plan:
- Async reset: rst=1 asserted mid-cycle with the registers loaded (mem_wdata=0x12345678) -> every output is 0 before the next clk edge; mem_valid=0.
- Normal advance: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0xDEADBEEF, ex_whilo=1, ex_hi=0x1, ex_lo=0x2 -> next edge: mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF, mem_whilo=1, mem_hi=1, mem_lo=2, mem_valid=1, cnt_o=0.
- MADD accumulate (HILO_ACC_EN): stall=6'b001111, hilo_i=0x0000_0001_0000_0002, cnt_i=1 -> mem_wreg=0, mem_whilo=0, mem_valid=0, hilo_o=0x0000_0001_0000_0002, cnt_o=1; then stall=0 -> hilo_o=0, cnt_o=0, EX values captured.
- Hold: load the registers, then stall=6'b011111 for 3 cycles while the ex_* inputs toggle -> mem_*, hilo_o and cnt_o are unchanged throughout.
- Flush beats stall: registers FULL, flush=1 with stall=6'b001111 -> next edge: all outputs 0, mem_valid=0, cnt_o=0.
- Illegal stall: stall=6'b010000 with new ex_* values -> registers hold their previous values.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results, sequences stall/flush, and parks the
// MADD/MSUB accumulator across EX stalls when HILO_ACC_EN is defined.
module ex_mem_reg #(
    parameter int unsigned REG_W   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned STALL_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    ex_wd,
    input  logic                 ex_wreg,
    input  logic [REG_W-1:0]     ex_wdata,
    input  logic [REG_W-1:0]     ex_hi,
    input  logic [REG_W-1:0]     ex_lo,
    input  logic                 ex_whilo,
`ifdef HILO_ACC_EN
    input  logic [2*REG_W-1:0]   hilo_i,
    input  logic [1:0]           cnt_i,
`endif
    output logic [ADDR_W-1:0]    mem_wd,
    output logic                 mem_wreg,
    output logic [REG_W-1:0]     mem_wdata,
    output logic [REG_W-1:0]     mem_hi,
    output logic [REG_W-1:0]     mem_lo,
    output logic                 mem_whilo,
    output logic                 mem_valid,
    output logic [2*REG_W-1:0]   hilo_o,
    output logic [1:0]           cnt_o
);

    localparam int unsigned EX_IDX  = 3;
    localparam int unsigned MEM_IDX = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [REG_W-1:0]  wdata;
        logic [REG_W-1:0]  hi;
        logic [REG_W-1:0]  lo;
        logic              whilo;
    } mem_pay_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    mem_pay_t    pay_q, pay_d, ex_pay;
    slot_state_t state_q, state_d;
    logic        advance, bubble;

    // Only the EX and MEM stall bits matter at this boundary.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:MEM_IDX+1], stall[EX_IDX-1:0]};

    assign ex_pay = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                      hi: ex_hi, lo: ex_lo, whilo: ex_whilo};

    // stall[4] without stall[3] is illegal from ctrl and falls through to hold.
    assign advance = !stall[EX_IDX] && !stall[MEM_IDX];
    assign bubble  =  stall[EX_IDX] && !stall[MEM_IDX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pay_q   <= '0;
            state_q <= EMPTY;
        end else begin
            pay_q   <= pay_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        pay_d   = pay_q;
        state_d = state_q;
        if (flush) begin
            pay_d   = '0;
            state_d = EMPTY;
        end else if (advance) begin
            pay_d   = ex_pay;
            state_d = FULL;
        end else if (bubble) begin
            pay_d   = '0;
            state_d = EMPTY;
        end
    end

`ifdef HILO_ACC_EN
    logic [2*REG_W-1:0] acc_q, acc_d;
    logic [1:0]         cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= 2'b00;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Accumulator survives only while EX is stalled behind a running MEM.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (flush || advance) begin
            acc_d = '0;
            cnt_d = 2'b00;
        end else if (bubble) begin
            acc_d = hilo_i;
            cnt_d = cnt_i;
        end
    end

    assign hilo_o = acc_q;
    assign cnt_o  = cnt_q;
`else
    assign hilo_o = '0;
    assign cnt_o  = 2'b00;
`endif

    assign mem_wd    = pay_q.wd;
    assign mem_wreg  = pay_q.wreg;
    assign mem_wdata = pay_q.wdata;
    assign mem_hi    = pay_q.hi;
    assign mem_lo    = pay_q.lo;
    assign mem_whilo = pay_q.whilo;
    assign mem_valid = (state_q == FULL);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg; covers accumulator steps when HILO_ACC_EN is set.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo, mem_valid;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
`ifdef HILO_ACC_EN
        .hilo_i(hilo_i), .cnt_i(cnt_i),
`endif
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] hi,
                           input logic [31:0] lo, input logic whilo, input logic valid,
                           input logic [63:0] hilo, input logic [1:0] cnt);
        chk({tag, ".wd"},    64'(mem_wd),    64'(wd));
        chk({tag, ".wreg"},  64'(mem_wreg),  64'(wreg));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
        chk({tag, ".hi"},    64'(mem_hi),    64'(hi));
        chk({tag, ".lo"},    64'(mem_lo),    64'(lo));
        chk({tag, ".whilo"}, 64'(mem_whilo), 64'(whilo));
        chk({tag, ".valid"}, 64'(mem_valid), 64'(valid));
        chk({tag, ".hilo"},  hilo_o,         hilo);
        chk({tag, ".cnt"},   64'(cnt_o),     64'(cnt));
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 6'b0; flush = 1'b0;
        hilo_i = 64'h0; cnt_i = 2'd0;
        drive(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        #2;
        chk_all("reset", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 2'd0);

        // Normal advance
        rst = 1'b0;
        drive(5'd5, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1);
        tick;
        chk_all("advance", 5'd5, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 1'b1, 64'h0, 2'd0);

        // Hold for 3 cycles while EX inputs toggle
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            drive(5'(i + 9), i[0], 32'hCAFE0000 + 32'(i), 32'h77, 32'h88, ~i[0]);
            tick;
            chk_all("hold", 5'd5, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 1'b1, 64'h0, 2'd0);
        end

        // Illegal encoding behaves as hold
        stall = 6'b010000;
        drive(5'd17, 1'b0, 32'h0BADF00D, 32'h33, 32'h44, 1'b0);
        tick;
        chk_all("illegal", 5'd5, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 1'b1, 64'h0, 2'd0);

        // Bubble (EX stalled, MEM runs)
        stall = 6'b001111;
        hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        tick;
`ifdef HILO_ACC_EN
        chk_all("bubble", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                64'h0000_0001_0000_0002, 2'd1);
        stall = 6'b011111;
        hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
        tick;
        chk_all("acc_hold", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                64'h0000_0001_0000_0002, 2'd1);
`else
        chk_all("bubble", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 2'd0);
`endif

        // Release stall: accumulation finishes, EX values captured
        stall = 6'b000000;
        drive(5'd7, 1'b1, 32'h55AA55AA, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
        tick;
        chk_all("release", 5'd7, 1'b1, 32'h55AA55AA, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1,
                64'h0, 2'd0);

        // HI/LO carried even when whilo is low
        drive(5'd31, 1'b1, 32'h00000001, 32'h12121212, 32'h34343434, 1'b0);
        tick;
        chk_all("nowhilo", 5'd31, 1'b1, 32'h00000001, 32'h12121212, 32'h34343434, 1'b0, 1'b1,
                64'h0, 2'd0);

        // Flush beats stall
        flush = 1'b1; stall = 6'b001111;
        hilo_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd2;
        tick;
        chk_all("flush", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 2'd0);
        flush = 1'b0; stall = 6'b000000;

        // Async reset mid-cycle with registers loaded
        drive(5'd3, 1'b1, 32'h12345678, 32'h9, 32'hA, 1'b1);
        tick;
        chk_all("load", 5'd3, 1'b1, 32'h12345678, 32'h9, 32'hA, 1'b1, 1'b1, 64'h0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 2'd0);
        rst = 1'b0;
        tick;
        chk_all("post_rst", 5'd3, 1'b1, 32'h12345678, 32'h9, 32'hA, 1'b1, 1'b1, 64'h0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
